// File: rtl/axil_to_apb_bridge.sv
// rtl/axil_to_apb_bridge.sv - AXI4-Lite slave to APB3 master bridge, one transfer outstanding
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module axil_to_apb_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic                m_psel,
  output logic                m_penable,
  output logic                m_pwrite,
  output logic [ADDR_W-1:0]   m_paddr,
  output logic [DATA_W-1:0]   m_pwdata,
  input  logic [DATA_W-1:0]   m_prdata,
  input  logic                m_pready,
  input  logic                m_pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t state;
  logic   last_grant_write;
  logic   idle, wr_cand, rd_cand, grant_write, grant_read;

  // Byte strobes are not forwarded; APB3 has no strobe signal.
  logic unused_sink;
  assign unused_sink = ^{s_wstrb, TIMEOUT_CYCLES > 1};

  assign idle    = (state == IDLE) && !preset;
  assign wr_cand = s_awvalid && s_wvalid;
  assign rd_cand = s_arvalid;

  // Round-robin: on a tie, serve the direction not granted last time.
  assign grant_write = idle && wr_cand && (!rd_cand || !last_grant_write);
  assign grant_read  = idle && rd_cand && (!wr_cand || last_grant_write);

  assign s_awready = grant_write;
  assign s_wready  = grant_write;
  assign s_arready = grant_read;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt;
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state            <= IDLE;
      last_grant_write <= 1'b0;
      m_psel           <= 1'b0;
      m_penable        <= 1'b0;
      m_pwrite         <= 1'b0;
      m_paddr          <= '0;
      m_pwdata         <= '0;
      s_bvalid         <= 1'b0;
      s_rvalid         <= 1'b0;
      s_bresp          <= RESP_OKAY;
      s_rresp          <= RESP_OKAY;
      s_rdata          <= '0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt          <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_write || grant_read) begin
            last_grant_write <= grant_write;
            m_pwrite         <= grant_write;
            m_paddr          <= grant_write ? s_awaddr : s_araddr;
            if (grant_write) m_pwdata <= s_wdata;
            m_psel           <= 1'b1;
            state            <= SETUP;
          end
        end
        SETUP: begin
          m_penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
          tmo_cnt   <= '0;
`endif
          state     <= ACCESS;
        end
        ACCESS: begin
          if (m_pready) begin
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            if (m_pwrite) begin
              s_bvalid <= 1'b1;
              s_bresp  <= m_pslverr ? RESP_SLVERR : RESP_OKAY;
            end else begin
              s_rvalid <= 1'b1;
              s_rresp  <= m_pslverr ? RESP_SLVERR : RESP_OKAY;
              s_rdata  <= m_prdata;
            end
            state <= RESP;
          end
`ifdef APB_TIMEOUT_EN
          else if (tmo_cnt == CNT_MAX) begin
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            if (m_pwrite) begin
              s_bvalid <= 1'b1;
              s_bresp  <= RESP_SLVERR;
            end else begin
              s_rvalid <= 1'b1;
              s_rresp  <= RESP_SLVERR;
              s_rdata  <= '0;
            end
            state <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if ((s_bvalid && s_bready) || (s_rvalid && s_rready)) begin
            s_bvalid <= 1'b0;
            s_rvalid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_to_apb_bridge.sv
// tb/tb_axil_to_apb_bridge.sv - directed self-checking bench for axil_to_apb_bridge
// Timeout branch is exercised only when APB_TIMEOUT_EN is defined.
module tb_axil_to_apb_bridge;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0, s_rdata;
  logic [3:0]  s_wstrb = 4'hF;
  logic        s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic        m_psel, m_penable, m_pwrite;
  logic [31:0] m_paddr, m_pwdata;
  logic [31:0] m_prdata = '0;
  logic        m_pready = 0, m_pslverr = 0;

  int passed = 0;
  int total  = 0;

  logic        ok;
  logic [1:0]  resp;
  logic [31:0] rd;

  axil_to_apb_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk), .preset(preset),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
    .m_pready(m_pready), .m_pslverr(m_pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One isolated transfer: request, SETUP, `waits` ACCESS wait states, completion, handshake.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input int waits, input logic err, input logic [31:0] prd,
                      output logic got_valid, output logic [1:0] got_resp,
                      output logic [31:0] got_rdata);
    if (wr) begin
      s_awaddr = addr; s_wdata = data; s_awvalid = 1; s_wvalid = 1;
    end else begin
      s_araddr = addr; s_arvalid = 1;
    end
    tick();
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    tick();
    repeat (waits) tick();
    m_pready = 1; m_pslverr = err; m_prdata = prd;
    tick();
    m_pready = 0; m_pslverr = 0;
    got_valid = wr ? s_bvalid : s_rvalid;
    got_resp  = wr ? s_bresp : s_rresp;
    got_rdata = s_rdata;
    s_bready = 1; s_rready = 1;
    tick();
    s_bready = 0; s_rready = 0;
  endtask

  initial begin
    // Reset state, with requests pending to show readies are held low
    tick();
    s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
    #1;
    check("rst_awready", s_awready, 0);
    check("rst_arready", s_arready, 0);
    check("rst_psel", m_psel, 0);
    check("rst_bvalid", s_bvalid, 0);
    check("rst_rvalid", s_rvalid, 0);
    check("rst_rdata", s_rdata, 0);
    tick();
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    preset = 0;
    tick();

    // 1: zero-wait write, latency N+1/N+2/N+3
    s_awaddr = 32'h4000_0010; s_wdata = 32'hDEAD_BEEF; s_awvalid = 1; s_wvalid = 1;
    #1;
    check("w1_awready", s_awready, 1);
    check("w1_wready", s_wready, 1);
    check("w1_arready", s_arready, 0);
    tick();
    s_awvalid = 0; s_wvalid = 0; m_pready = 1;
    check("w1_setup_psel", m_psel, 1);
    check("w1_setup_penable", m_penable, 0);
    check("w1_pwrite", m_pwrite, 1);
    check("w1_paddr", m_paddr, 32'h4000_0010);
    check("w1_pwdata", m_pwdata, 32'hDEAD_BEEF);
    tick();
    check("w1_access_psel", m_psel, 1);
    check("w1_access_penable", m_penable, 1);
    tick();
    check("w1_bvalid", s_bvalid, 1);
    check("w1_bresp", s_bresp, 2'b00);
    check("w1_psel_drop", m_psel, 0);
    check("w1_penable_drop", m_penable, 0);
    s_bready = 1;
    tick();
    s_bready = 0; m_pready = 0;
    check("w1_bvalid_clr", s_bvalid, 0);

    // 2: read with 3 wait states
    s_araddr = 32'h5000_0004; s_arvalid = 1;
    #1;
    check("r2_arready", s_arready, 1);
    check("r2_awready", s_awready, 0);
    tick();
    s_arvalid = 0;
    check("r2_pwrite", m_pwrite, 0);
    check("r2_paddr", m_paddr, 32'h5000_0004);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("r2_wait_penable", m_penable, 1);
      check("r2_wait_paddr", m_paddr, 32'h5000_0004);
      check("r2_wait_rvalid", s_rvalid, 0);
      tick();
    end
    m_pready = 1; m_prdata = 32'h1234_5678;
    tick();
    m_pready = 0; m_prdata = 32'hFFFF_0000;
    check("r2_rvalid", s_rvalid, 1);
    check("r2_rdata", s_rdata, 32'h1234_5678);
    check("r2_rresp", s_rresp, 2'b00);
    tick();
    check("r2_rvalid_held", s_rvalid, 1);
    check("r2_rdata_held", s_rdata, 32'h1234_5678);
    s_rready = 1;
    tick();
    s_rready = 0;
    check("r2_rvalid_clr", s_rvalid, 0);

    // 3: slave errors; a write must not disturb s_rdata
    xfer(1, 32'h4000_0020, 32'h0BAD_0BAD, 1, 1, 32'h7777_7777, ok, resp, rd);
    check("e3_w_bvalid", ok, 1);
    check("e3_w_bresp", resp, 2'b10);
    check("e3_w_rdata_kept", rd, 32'h1234_5678);
    xfer(0, 32'h5000_0040, 32'h0, 0, 1, 32'hCAFE_F00D, ok, resp, rd);
    check("e3_r_rvalid", ok, 1);
    check("e3_r_rresp", resp, 2'b10);
    check("e3_r_rdata", rd, 32'hCAFE_F00D);

    // 4: simultaneous requests after reset alternate W,R,W,R at 4 cycles each
    preset = 1;
    tick();
    preset = 0;
    tick();
    s_awaddr = 32'h4000_0100; s_wdata = 32'h0000_0001; s_araddr = 32'h5000_0200;
    s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
    m_pready = 1; s_bready = 1; s_rready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("a4_awready", s_awready, (k % 2 == 0));
      check("a4_arready", s_arready, (k % 2 != 0));
      tick();
      check("a4_pwrite", m_pwrite, (k % 2 == 0));
      check("a4_arready_busy", s_arready, 0);
      tick();
      tick();
      check("a4_resp_valid", (k % 2 == 0) ? s_bvalid : s_rvalid, 1);
      tick();
    end
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    m_pready = 0; s_bready = 0; s_rready = 0;
    m_prdata = 32'h5555_AAAA;
    tick();

    // 5: ACCESS with pready held low
    s_araddr = 32'h5000_0008; s_arvalid = 1;
    tick();
    s_arvalid = 0;
    tick();
`ifdef APB_TIMEOUT_EN
    repeat (15) tick();
    check("t5_psel_last", m_psel, 1);
    check("t5_penable_last", m_penable, 1);
    tick();
    check("t5_psel_abort", m_psel, 0);
    check("t5_rvalid", s_rvalid, 1);
    check("t5_rresp", s_rresp, 2'b10);
    check("t5_rdata", s_rdata, 0);
    s_rready = 1;
    tick();
    s_rready = 0;
    s_awaddr = 32'h4000_0300; s_wdata = 32'h1111_2222; s_awvalid = 1; s_wvalid = 1;
    tick();
    s_awvalid = 0; s_wvalid = 0;
    repeat (3) tick();
`else
    repeat (1000) tick();
    check("t5_psel_stuck", m_psel, 1);
    check("t5_penable_stuck", m_penable, 1);
    check("t5_rvalid_none", s_rvalid, 0);
`endif

    // 6: reset during ACCESS clears outputs immediately, then a write completes
    preset = 1;
    #1;
    check("p6_psel", m_psel, 0);
    check("p6_penable", m_penable, 0);
    check("p6_paddr", m_paddr, 0);
    check("p6_rvalid", s_rvalid, 0);
    check("p6_bvalid", s_bvalid, 0);
    tick();
    preset = 0;
    tick();
    xfer(1, 32'h4000_0400, 32'hA5A5_5A5A, 0, 0, 32'h0, ok, resp, rd);
    check("p6_w_bvalid", ok, 1);
    check("p6_w_bresp", resp, 2'b00);
    check("p6_pwdata", m_pwdata, 32'hA5A5_5A5A);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
